// File: rtl/sync_mem_pkg.sv
// -----------------------------------------------------------------------------
// sync_mem_pkg
// Shared definitions for the sync_mem request/complete memory block:
//   - default parameter values used by sync_mem and its array
//   - state encoding type and state constants for the control FSM
//   - width of the latency down-counter (supports LATENCY 1..15)
//   - helper to size the array index from the word count
// -----------------------------------------------------------------------------
package sync_mem_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DEPTH   = 20;
    localparam int DEF_LATENCY = 2;

    // Down-counter width; LATENCY-1 never exceeds 14.
    localparam int CNT_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_INIT = 2'd0;
    localparam state_t ST_IDLE = 2'd1;
    localparam state_t ST_BUSY = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Index width for a DEPTH-word array; a single-word array still needs one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_mem_array.sv
// -----------------------------------------------------------------------------
// sync_mem_array
// DEPTH x DATA_W storage with one write port and one synchronous read port.
// Contents are never reset; the owner clears them with its own write sweep.
//
// Ports
//   clk      : clock, all activity on the rising edge
//   i_we     : write enable
//   i_waddr  : write word index
//   i_wdata  : write data
//   i_re     : read enable; o_rdata updates on the edge where i_re is high
//   i_raddr  : read word index
//   o_rdata  : registered read data, held until the next enabled read
// -----------------------------------------------------------------------------
module sync_mem_array
    import sync_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = idx_width(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Index bits can encode more than DEPTH words when DEPTH is not a power
    // of two; those indices are simply ignored here.
    logic w_wr_ok;
    logic w_rd_ok;

    assign w_wr_ok = (32'(i_waddr) < 32'(DEPTH));
    assign w_rd_ok = (32'(i_raddr) < 32'(DEPTH));

    always_ff @(posedge clk) begin
        if (i_we && w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= w_rd_ok ? r_mem[i_raddr] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_mem.sv
// -----------------------------------------------------------------------------
// sync_mem
// Word memory with a four-phase request/complete handshake. After reset the
// array is cleared one word per cycle; then each request held on EN is
// accepted in IDLE, completes LATENCY cycles later with MFC high, and MFC
// stays high until the master drops EN.
//
// Ports
//   clk      : clock
//   reset    : asynchronous, active-high reset
//   EN       : request, held by the master until MFC is seen
//   R_W      : 1 = read, 0 = write (sampled at accept)
//   address  : word address (sampled at accept)
//   dataIn   : write data (sampled at accept)
//   dataOut  : read data, valid while MFC is high after a read, 0 otherwise
//   MFC      : memory function complete
//   err      : address was out of range, valid while MFC is high
//   ready    : clear sweep finished and FSM idle
//
// state   | meaning
// --------+------------------------------------------------------------------
// INIT    | writing zero to word r_index, one word per cycle; EN ignored
// IDLE    | waiting for EN; accept latches R_W/address/dataIn, loads counter
// BUSY    | counting down; at terminal count the access is performed
// DONE    | MFC high, outputs held; leaves when EN is low
// -----------------------------------------------------------------------------
module sync_mem
    import sync_mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EN,
    input  logic              R_W,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              MFC,
    output logic              err,
    output logic              ready
);

    localparam int                IDX_W     = idx_width(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);
    // One extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t             r_state;
    logic [IDX_W-1:0]   r_index;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rw;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_err;
    logic               r_is_read;

    logic               w_access;
    logic               w_oor;
    logic [IDX_W-1:0]   w_addr_idx;
    logic               w_arr_we;
    logic [IDX_W-1:0]   w_arr_waddr;
    logic [DATA_W-1:0]  w_arr_wdata;
    logic               w_arr_re;
    logic [DATA_W-1:0]  w_arr_rdata;
    logic               w_done;

    // Terminal count of the latency timer: the access happens on this edge.
    assign w_access   = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_oor      = ({1'b0, r_addr} >= DEPTH_EXT);
    assign w_addr_idx = r_addr[IDX_W-1:0];

    // The clear sweep owns the write port in INIT; otherwise only an
    // in-range write access may store.
    always_comb begin
        w_arr_we    = 1'b0;
        w_arr_waddr = w_addr_idx;
        w_arr_wdata = r_wdata;
        if (r_state == ST_INIT) begin
            w_arr_we    = 1'b1;
            w_arr_waddr = r_index;
            w_arr_wdata = '0;
        end else if (w_access && !r_rw && !w_oor) begin
            w_arr_we = 1'b1;
        end
    end

    assign w_arr_re = w_access && r_rw && !w_oor;

    sync_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_waddr (w_arr_waddr),
        .i_wdata (w_arr_wdata),
        .i_re    (w_arr_re),
        .i_raddr (w_addr_idx),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_INIT;
            r_index   <= '0;
            r_cnt     <= '0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_is_read <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_index == LAST_IDX) begin
                        r_index <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_index <= r_index + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (EN) begin
                        r_rw    <= R_W;
                        r_addr  <= address;
                        r_wdata <= dataIn;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_err     <= w_oor;
                        r_is_read <= r_rw;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    // Completion is shown for at least one cycle even if EN
                    // was already dropped during BUSY.
                    if (!EN) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // Outputs are gated by DONE so they vanish the cycle after leaving it
    // and are forced low immediately by reset.
    assign w_done  = (r_state == ST_DONE);
    assign MFC     = w_done;
    assign err     = w_done && r_err;
    assign dataOut = (w_done && r_is_read && !r_err) ? w_arr_rdata : '0;
    assign ready   = (r_state == ST_IDLE);

endmodule

// File: tb/tb_sync_mem.sv
module tb_sync_mem;

    logic        clk;
    logic        reset;

    logic        en_a, rw_a;
    logic [15:0] addr_a, din_a, dout_a;
    logic        mfc_a, err_a, ready_a;

    logic        en_b, rw_b;
    logic [15:0] addr_b;
    logic [31:0] din_b, dout_b;
    logic        mfc_b, err_b, ready_b;

    int n_checks = 0;
    int n_err    = 0;

    sync_mem u_dut_a (
        .clk     (clk),
        .reset   (reset),
        .EN      (en_a),
        .R_W     (rw_a),
        .address (addr_a),
        .dataIn  (din_a),
        .dataOut (dout_a),
        .MFC     (mfc_a),
        .err     (err_a),
        .ready   (ready_a)
    );

    sync_mem #(
        .DATA_W  (32),
        .ADDR_W  (16),
        .DEPTH   (64),
        .LATENCY (1)
    ) u_dut_b (
        .clk     (clk),
        .reset   (reset),
        .EN      (en_b),
        .R_W     (rw_b),
        .address (addr_b),
        .dataIn  (din_b),
        .dataOut (dout_b),
        .MFC     (mfc_b),
        .err     (err_b),
        .ready   (ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic en, input logic rw,
                         input logic [15:0] adr, input logic [31:0] dat);
        if (sel) begin
            en_b = en; rw_b = rw; addr_b = adr; din_b = dat;
        end else begin
            en_a = en; rw_a = rw; addr_a = adr; din_a = dat[15:0];
        end
    endtask

    // Full handshake: raise EN in IDLE, scramble inputs after accept, wait
    // for MFC, capture outputs, drop EN and take the DONE->IDLE edge.
    task automatic req(input bit sel, input logic rw, input logic [15:0] adr,
                       input logic [31:0] dat, input bit drop_early,
                       output int lat, output logic [31:0] dout, output logic e);
        drive(sel, 1'b1, rw, adr, dat);
        tick();
        drive(sel, !drop_early, ~rw, ~adr, ~dat);
        lat = 0;
        while (!(sel ? mfc_b : mfc_a) && lat < 40) begin
            tick();
            lat++;
        end
        dout = sel ? dout_b : {16'h0, dout_a};
        e    = sel ? err_b : err_a;
        drive(sel, 1'b0, 1'b0, 16'h0, 32'h0);
        tick();
    endtask

    initial begin
        int          lat;
        int          cyc_a, cyc_b, cyc;
        logic [31:0] dout;
        logic        e;
        logic [15:0] model [20];
        bit          mfc_seen;

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
        for (int i = 0; i < 20; i++) model[i] = 16'h0;
        tick(); tick(); tick();

        chk("rst_ready_a", {31'h0, ready_a}, 32'h0);
        chk("rst_mfc_a",   {31'h0, mfc_a},   32'h0);
        chk("rst_err_a",   {31'h0, err_a},   32'h0);
        chk("rst_dout_a",  {16'h0, dout_a},  32'h0);
        chk("rst_ready_b", {31'h0, ready_b}, 32'h0);
        chk("rst_dout_b",  dout_b,           32'h0);

        // Ready must rise exactly DEPTH cycles after reset release.
        reset = 1'b0;
        cyc = 0; cyc_a = -1; cyc_b = -1;
        while ((cyc_a < 0 || cyc_b < 0) && cyc < 200) begin
            tick();
            cyc++;
            if (ready_a && cyc_a < 0) cyc_a = cyc;
            if (ready_b && cyc_b < 0) cyc_b = cyc;
        end
        chk("init_cycles_a", 32'(cyc_a), 32'd20);
        chk("init_cycles_b", 32'(cyc_b), 32'd64);

        for (int i = 0; i < 20; i++) begin
            req(0, 1'b1, 16'(i), 32'h0, 0, lat, dout, e);
            chk("init_read_zero", dout, 32'h0);
            chk("init_read_err",  {31'h0, e}, 32'h0);
        end

        req(0, 1'b0, 16'd3, 32'h9410, 0, lat, dout, e);
        model[3] = 16'h9410;
        chk("wr3_latency", 32'(lat), 32'd2);
        chk("wr3_err",     {31'h0, e}, 32'h0);
        chk("wr3_mfc_drop", {31'h0, mfc_a}, 32'h0);

        req(0, 1'b1, 16'd3, 32'h0, 0, lat, dout, e);
        chk("rd3_latency", 32'(lat), 32'd2);
        chk("rd3_data",    dout, 32'h9410);
        chk("rd3_err",     {31'h0, e}, 32'h0);
        chk("rd3_mfc_drop", {31'h0, mfc_a}, 32'h0);
        chk("rd3_dout_zero", {16'h0, dout_a}, 32'h0);

        req(0, 1'b1, 16'd20, 32'h0, 0, lat, dout, e);
        chk("rd20_data", dout, 32'h0);
        chk("rd20_err",  {31'h0, e}, 32'h1);
        chk("rd20_err_drop", {31'h0, err_a}, 32'h0);

        req(0, 1'b0, 16'd25, 32'hAAAA, 0, lat, dout, e);
        chk("wr25_err", {31'h0, e}, 32'h1);
        req(0, 1'b0, 16'd36, 32'hBBBB, 0, lat, dout, e);
        chk("wr36_err", {31'h0, e}, 32'h1);

        req(0, 1'b0, 16'd19, 32'h7E57, 0, lat, dout, e);
        model[19] = 16'h7E57;
        chk("wr19_err", {31'h0, e}, 32'h0);

        for (int i = 0; i < 20; i++) begin
            req(0, 1'b1, 16'(i), 32'h0, 0, lat, dout, e);
            chk("sweep_read", dout, {16'h0, model[i]});
        end

        // EN held 5 cycles past MFC; inputs changed meanwhile.
        drive(0, 1'b1, 1'b0, 16'd10, 32'h0055);
        tick();
        drive(0, 1'b1, 1'b1, 16'd11, 32'h0066);
        lat = 0;
        while (!mfc_a && lat < 40) begin
            tick();
            lat++;
        end
        chk("hold_latency", 32'(lat), 32'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_mfc_high", {31'h0, mfc_a}, 32'h1);
        end
        chk("hold_ready_low", {31'h0, ready_a}, 32'h0);
        drive(0, 1'b0, 1'b1, 16'd11, 32'h0066);
        tick();
        chk("hold_mfc_drop", {31'h0, mfc_a}, 32'h0);
        chk("hold_ready_back", {31'h0, ready_a}, 32'h1);
        tick();
        chk("hold_no_second", {31'h0, mfc_a}, 32'h0);
        req(0, 1'b1, 16'd10, 32'h0, 0, lat, dout, e);
        chk("hold_rd10", dout, 32'h0055);
        req(0, 1'b1, 16'd11, 32'h0, 0, lat, dout, e);
        chk("hold_rd11", dout, 32'h0);

        // EN dropped during BUSY: MFC for exactly one cycle.
        req(0, 1'b1, 16'd3, 32'h0, 1, lat, dout, e);
        chk("early_latency", 32'(lat), 32'd2);
        chk("early_data",    dout, 32'h9410);
        chk("early_one_cycle", {31'h0, mfc_a}, 32'h0);

        req(0, 1'b0, 16'd5, 32'h1234, 0, lat, dout, e);
        req(0, 1'b1, 16'd5, 32'h0, 0, lat, dout, e);
        chk("rd5_data", dout, 32'h1234);

        // Reset during BUSY of a write to address 7.
        drive(0, 1'b1, 1'b0, 16'd7, 32'hFFFF);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("busy_rst_mfc",   {31'h0, mfc_a},   32'h0);
        chk("busy_rst_ready", {31'h0, ready_a}, 32'h0);
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        mfc_seen = 1'b0;
        tick(); tick();
        if (mfc_a) mfc_seen = 1'b1;
        reset = 1'b0;
        cyc = 0;
        while (!(ready_a && ready_b) && cyc < 200) begin
            tick();
            cyc++;
            if (mfc_a) mfc_seen = 1'b1;
        end
        chk("busy_rst_no_mfc", {31'h0, mfc_seen}, 32'h0);
        chk("busy_rst_reinit", {31'h0, ready_a && ready_b}, 32'h1);
        req(0, 1'b1, 16'd7, 32'h0, 0, lat, dout, e);
        chk("busy_rst_rd7", dout, 32'h0);
        req(0, 1'b1, 16'd5, 32'h0, 0, lat, dout, e);
        chk("busy_rst_rd5", dout, 32'h0);

        // Wide instance: DATA_W=32, DEPTH=64, LATENCY=1.
        req(1, 1'b0, 16'd63, 32'hDEADBEEF, 0, lat, dout, e);
        chk("b_wr63_latency", 32'(lat), 32'd1);
        chk("b_wr63_err",     {31'h0, e}, 32'h0);
        req(1, 1'b1, 16'd63, 32'h0, 0, lat, dout, e);
        chk("b_rd63_latency", 32'(lat), 32'd1);
        chk("b_rd63_data",    dout, 32'hDEADBEEF);
        chk("b_rd63_mfc_drop", {31'h0, mfc_b}, 32'h0);
        req(1, 1'b1, 16'd64, 32'h0, 0, lat, dout, e);
        chk("b_rd64_err",  {31'h0, e}, 32'h1);
        chk("b_rd64_data", dout, 32'h0);
        req(1, 1'b1, 16'd62, 32'h0, 0, lat, dout, e);
        chk("b_rd62_data", dout, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_mem.md
SYNC_MEM -- requirements
Module: sync_mem

Interface
REQ-001 Parameter DATA_W, default 16: data word width in bits.
REQ-002 Parameter ADDR_W, default 16: address width in bits.
REQ-003 Parameter DEPTH, default 20: number of words; SHALL be ≤ 2^ADDR_W.
REQ-004 Parameter LATENCY, default 2: cycles from request accept to MFC assertion; legal range 1..15.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 EN  input  1  request; level-held by master until MFC seen.
REQ-008 R_W  input  1  1 = read, 0 = write; sampled at accept.
REQ-009 address  input  ADDR_W  word address; sampled at accept.
REQ-010 dataIn  input  DATA_W  write data; sampled at accept.
REQ-011 dataOut  output  DATA_W  read data; valid while MFC high after a read.
REQ-012 MFC  output  1  memory-function-complete.
REQ-013 err  output  1  out-of-range address flag; valid while MFC high.
REQ-014 ready  output  1  high when the initial clear sweep is done and the FSM is in IDLE.

Function
REQ-015 FSM states: INIT, IDLE, BUSY, DONE.
REQ-016 INIT: write zero to one word per cycle, index 0..DEPTH-1; after the last word, go to IDLE (DEPTH cycles total); EN ignored.
REQ-017 IDLE: if EN=1, latch R_W, address and dataIn, load the latency counter with LATENCY-1, and go to BUSY.
REQ-018 BUSY: decrement the counter each cycle; at zero, perform the access and go to DONE.
REQ-019 Access: a read loads dataOut with mem[address]; a write stores the latched dataIn to mem[address].
REQ-020 Out-of-range (address ≥ DEPTH): write suppressed, read returns dataOut = 0, err = 1.
REQ-021 DONE: MFC = 1; hold dataOut and err stable; when EN = 0, go to IDLE (four-phase handshake).
REQ-022 Accept-to-MFC latency is exactly LATENCY cycles; MFC rises LATENCY clocks after the accept edge.
REQ-023 MFC, err and dataOut deassert/zero on the cycle after leaving DONE; back-to-back requests need EN low for ≥1 cycle.
REQ-024 Changes to address, dataIn or R_W during BUSY or DONE have no effect.
REQ-025 EN already low when DONE is entered: MFC SHALL still be high for exactly one cycle.
REQ-026 dataOut SHALL never be driven to Z.

Reset
REQ-027 Reset SHALL force state = INIT, clear index = 0, MFC = 0, err = 0, ready = 0, dataOut = 0, and counter = 0, immediately and asynchronously.
REQ-028 Reset mid-BUSY SHALL abort the access with no write; the memory is re-cleared by INIT.
REQ-029 Memory array contents are not reset asynchronously; they are zeroed only by the INIT sweep.

Structure
REQ-030 The package sync_mem_pkg SHALL hold the state encoding type and the default parameter constants.
REQ-031 The storage array SHALL be a sub-module sync_mem_array (1 write port, 1 synchronous read port, DEPTH × DATA_W); FSM and handshake logic stay in sync_mem.

Verification
REQ-032 Reset release -> ready rises exactly 20 cycles later; reads of addresses 0..19 return 0.
REQ-033 Write 0x9410 to address 3, then read address 3 with LATENCY = 2 -> MFC rises 2 cycles after each accept; dataOut = 0x9410; err = 0.
REQ-034 Read address 20 (DEPTH = 20) -> dataOut = 0 and err = 1; write to address 25 -> err = 1 and no array word changes.
REQ-035 Hold EN high 5 cycles past MFC -> MFC stays high for 5 cycles, then drops 1 cycle after EN falls; there is no second access.
REQ-036 Assert reset during BUSY of a write of 0xFFFF to address 7 -> MFC is never asserted; after INIT, address 7 reads 0.
REQ-037 Parameter sweep with DATA_W = 32, DEPTH = 64, LATENCY = 1 -> write/read of 0xDEADBEEF to address 63 returns the same value; MFC rises 1 cycle after accept.
